// File: rtl/pram_loader_pkg.sv
// rtl/pram_loader_pkg.sv - shared state encoding and defaults for the PRAM boot loader
package pram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam int DEFAULT_TIMEOUT_CYC = 255;

    function automatic logic is_busy(input state_t s);
        return (s == ST_REQ) || (s == ST_WAIT) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/pram_loader_wb_timeout_cnt.sv
// rtl/pram_loader_wb_timeout_cnt.sv - clearable per-word Wishbone wait counter
module wb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic a_reset_l,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates so a long run of retries can never wrap back below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge a_reset_l) begin
        if (!a_reset_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the cycle whose increment reaches the limit.
    assign expired_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/pram_loader.sv
// rtl/pram_loader.sv - boot-time Wishbone-to-PRAM image copier; PRAM_LOADER_CHKSUM_EN adds a running checksum
module pram_loader
    import pram_loader_pkg::*;
#(
    parameter int INSTR_WIDTH   = 16,
    parameter int ADDR_WIDTH_PC = 12,
    parameter int TIMEOUT_CYC   = DEFAULT_TIMEOUT_CYC
) (
    input  logic                     clk_i,
    input  logic                     a_reset_l,
    input  logic                     init_start_i,
    input  logic [ADDR_WIDTH_PC-1:0] base_adr_i,
    input  logic [ADDR_WIDTH_PC-1:0] load_len_i,
    output logic                     wb_start_o,
    input  logic                     wb_ack_i,
    input  logic                     valid_i,
    input  logic [INSTR_WIDTH-1:0]   data_wb_bus_i,
    output logic                     pram_we_o,
    output logic [ADDR_WIDTH_PC-1:0] pram_adr_o,
    output logic [INSTR_WIDTH-1:0]   pram_data_o,
    output logic                     cpu_stall_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [INSTR_WIDTH-1:0]   chksum_o
);

    localparam logic [ADDR_WIDTH_PC-1:0] LEN_ONE = ADDR_WIDTH_PC'(1);

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH_PC-1:0] adr_q, adr_d;
    logic [ADDR_WIDTH_PC-1:0] rem_q, rem_d;
    logic [INSTR_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH_PC-1:0] pram_adr_q, pram_adr_d;
    logic                     err_q, err_d;
    logic                     wb_start_q, pram_we_q, busy_q, done_q;

    logic start_ok;
    logic word_ok;
    logic tmo_en;
    logic tmo_expired;

    assign start_ok = init_start_i && ((state_q == ST_IDLE) || (state_q == ST_ERR));
    assign word_ok  = (state_q == ST_WAIT) && wb_ack_i && valid_i;
    assign tmo_en   = (state_q == ST_REQ) || ((state_q == ST_WAIT) && !word_ok);

    wb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk_i    (clk_i),
        .a_reset_l(a_reset_l),
        .clr_i    (start_ok || word_ok),
        .en_i     (tmo_en),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        rem_d      = rem_q;
        data_d     = data_q;
        pram_adr_d = pram_adr_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (init_start_i) begin
                    if (load_len_i != '0) begin
                        adr_d   = base_adr_i;
                        rem_d   = load_len_i;
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            // A valid word wins over a coincident expiry; an invalid ack only retries if time remains.
            ST_WAIT: begin
                if (word_ok) begin
                    data_d     = data_wb_bus_i;
                    pram_adr_d = adr_q;
                    state_d    = ST_WRITE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (wb_ack_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_WRITE: begin
                adr_d   = adr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == LEN_ONE) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk_i or negedge a_reset_l) begin
        if (!a_reset_l) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            pram_adr_q <= '0;
            err_q      <= 1'b0;
            wb_start_q <= 1'b0;
            pram_we_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            pram_adr_q <= pram_adr_d;
            err_q      <= err_d;
            wb_start_q <= (state_d == ST_REQ);
            pram_we_q  <= (state_d == ST_WRITE);
            busy_q     <= is_busy(state_d);
            done_q     <= (state_d == ST_DONE);
        end
    end

`ifdef PRAM_LOADER_CHKSUM_EN
    logic [INSTR_WIDTH-1:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (start_ok) begin
            chksum_d = '0;
        end else if (state_q == ST_WRITE) begin
            chksum_d = chksum_q + data_q;
        end
    end

    always_ff @(posedge clk_i or negedge a_reset_l) begin
        if (!a_reset_l) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign chksum_o = chksum_q;
`else
    assign chksum_o = '0;
`endif

    assign wb_start_o  = wb_start_q;
    assign pram_we_o   = pram_we_q;
    assign pram_adr_o  = pram_adr_q;
    assign pram_data_o = data_q;
    assign cpu_stall_o = busy_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pram_loader.sv
// tb/tb_pram_loader.sv - self-checking bench for pram_loader
module tb_pram_loader;

    localparam int IW  = 16;
    localparam int AW  = 12;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          a_reset_l = 1'b0;
    logic          init_start = 1'b0;
    logic [AW-1:0] base_adr = '0;
    logic [AW-1:0] load_len = '0;
    logic          wb_ack = 1'b0;
    logic          valid = 1'b0;
    logic [IW-1:0] data_wb = '0;
    logic          wb_start, pram_we, cpu_stall, busy, done, err;
    logic [AW-1:0] pram_adr;
    logic [IW-1:0] pram_data, chksum;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_starts = 0;

    logic [AW-1:0] wr_adr_q[$];
    logic [IW-1:0] wr_dat_q[$];
    int            done_cyc_q[$];
    logic [IW-1:0] done_sum_q[$];
    logic [IW-1:0] wq[$];
    logic [IW-1:0] exp_w[$];
    int            inval_left = 0;
    bit            no_ack = 1'b0;
    bit            pend = 1'b0;

    always #5 clk = ~clk;

    pram_loader #(
        .INSTR_WIDTH  (IW),
        .ADDR_WIDTH_PC(AW),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk_i        (clk),
        .a_reset_l    (a_reset_l),
        .init_start_i (init_start),
        .base_adr_i   (base_adr),
        .load_len_i   (load_len),
        .wb_start_o   (wb_start),
        .wb_ack_i     (wb_ack),
        .valid_i      (valid),
        .data_wb_bus_i(data_wb),
        .pram_we_o    (pram_we),
        .pram_adr_o   (pram_adr),
        .pram_data_o  (pram_data),
        .cpu_stall_o  (cpu_stall),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .chksum_o     (chksum)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Wishbone responder: answers in the cycle after each request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            wb_ack = 1'b0;
            valid  = 1'b0;
            if (pend && !no_ack && a_reset_l) begin
                wb_ack = 1'b1;
                if (inval_left > 0) begin
                    data_wb = IW'($urandom);
                    inval_left--;
                end else begin
                    valid   = 1'b1;
                    data_wb = (wq.size() > 0) ? wq.pop_front() : '0;
                end
            end
            pend = wb_start && a_reset_l;
        end
    end

    initial forever begin
        @(negedge clk);
        if (wb_start) n_starts++;
        if (pram_we) begin
            wr_adr_q.push_back(pram_adr);
            wr_dat_q.push_back(pram_data);
        end
        if (done) begin
            done_cyc_q.push_back(cyc);
            done_sum_q.push_back(chksum);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({wb_start, pram_we, cpu_stall, busy, done, err, pram_adr, pram_data, chksum});
    endfunction

    task automatic clear_logs();
        wr_adr_q   = {};
        wr_dat_q   = {};
        done_cyc_q = {};
        done_sum_q = {};
        n_starts   = 0;
    endtask

    // Expected behaviour from the load rules: words land at base+i (mod 2^AW), 3 cycles per word,
    // 2 extra per rejected ack, done one cycle after the last write.
    task automatic do_load(input logic [AW-1:0] base, input int inv, input string tag);
        int            s;
        int            n;
        logic [IW-1:0] sum;
        logic [63:0]   o;
        n   = exp_w.size();
        sum = '0;
        foreach (exp_w[i]) sum += exp_w[i];
`ifndef PRAM_LOADER_CHKSUM_EN
        sum = '0;
`endif
        @(posedge clk);
        #1;
        clear_logs();
        wq         = exp_w;
        inval_left = inv;
        no_ack     = 1'b0;
        base_adr   = base;
        load_len   = AW'(n);
        init_start = 1'b1;
        s          = cyc;
        @(posedge clk);
        #1;
        init_start = 1'b0;
        for (int k = 0; k < 3 * n + 2 * inv + 10; k++) begin
            @(negedge clk);
            if (done_cyc_q.size() != 0) break;
        end
        repeat (3) @(negedge clk);
        check({tag, " done_count"}, 64'(done_cyc_q.size()), 64'd1);
        check({tag, " done_latency"}, (done_cyc_q.size() > 0) ? 64'(done_cyc_q[0] - s) : '1,
              64'(3 * n + 1 + 2 * inv));
        check({tag, " chksum"}, (done_sum_q.size() > 0) ? 64'(done_sum_q[0]) : 'x, 64'(sum));
        check({tag, " wb_starts"}, 64'(n_starts), 64'(n + inv));
        check({tag, " write_count"}, 64'(wr_adr_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            o = 'x;
            if (i < wr_adr_q.size()) o = 64'(wr_adr_q[i]);
            check($sformatf("%s wr_adr[%0d]", tag, i), o, 64'((int'(base) + i) % (1 << AW)));
            o = 'x;
            if (i < wr_dat_q.size()) o = 64'(wr_dat_q[i]);
            check($sformatf("%s wr_dat[%0d]", tag, i), o, 64'(exp_w[i]));
        end
        check({tag, " idle_flags"}, 64'({busy, cpu_stall, err}), 64'd0);
    endtask

    task automatic rand_words(input int n);
        exp_w = {};
        for (int i = 0; i < n; i++) exp_w.push_back(IW'($urandom));
    endtask

    initial begin
        int          s;
        int          e;
        logic [AW-1:0] b;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        a_reset_l = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_outputs", all_outs(), 64'd0);

        exp_w = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_load(12'h000, 0, "len4_base0");

        rand_words(3);
        do_load(12'hFFE, 0, "wrap_FFE");

        exp_w = {};
        do_load(12'h123, 0, "empty");

        rand_words(2);
        do_load(12'h040, 1, "invalid_ack");

        for (int r = 0; r < 4; r++) begin
            rand_words($urandom_range(1, 6));
            b = AW'($urandom);
            do_load(b, $urandom_range(0, 1), $sformatf("rand%0d", r));
        end

        // Timeout: no acks at all.
        @(posedge clk);
        #1;
        clear_logs();
        no_ack     = 1'b1;
        base_adr   = 12'h200;
        load_len   = 12'd2;
        init_start = 1'b1;
        s          = cyc;
        @(posedge clk);
        #1;
        init_start = 1'b0;
        e = -1;
        for (int k = 0; k < TMO + 6; k++) begin
            @(negedge clk);
            if (err) begin
                e = cyc - (s + 1);
                break;
            end
        end
        check("tmo_err_seen", 64'(err), 64'd1);
        check("tmo_within_limit", 64'((e > 0) && (e <= TMO)), 64'd1);
        check("tmo_busy_stall", 64'({busy, cpu_stall}), 64'd0);
        repeat (5) @(negedge clk);
        check("tmo_err_held", 64'(err), 64'd1);
        check("tmo_no_done", 64'(done_cyc_q.size()), 64'd0);
        check("tmo_no_write", 64'(wr_adr_q.size()), 64'd0);
        rand_words(3);
        do_load(12'h300, 0, "after_tmo");

        // Reset in the middle of the second word.
        rand_words(4);
        @(posedge clk);
        #1;
        clear_logs();
        wq         = exp_w;
        no_ack     = 1'b0;
        inval_left = 0;
        base_adr   = 12'h080;
        load_len   = 12'd4;
        init_start = 1'b1;
        @(posedge clk);
        #1;
        init_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (n_starts >= 2) break;
        end
        check("rst_second_req_seen", 64'(n_starts), 64'd2);
        #2;
        a_reset_l = 1'b0;
        #1;
        check("rst_async_outputs", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_held_outputs", all_outs(), 64'd0);
        a_reset_l = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_done", 64'(done_cyc_q.size()), 64'd0);
        check("rst_one_write", 64'(wr_adr_q.size()), 64'd1);
        check("rst_first_adr", (wr_adr_q.size() > 0) ? 64'(wr_adr_q[0]) : 'x, 64'h080);
        check("rst_first_dat", (wr_dat_q.size() > 0) ? 64'(wr_dat_q[0]) : 'x, 64'(exp_w[0]));
        rand_words(4);
        do_load(12'h080, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
